// File: rtl/imem_loader.sv
// Byte-stream boot loader: receives a 16-bit little-endian word count followed by
// little-endian data words and writes them into instruction memory while holding the core.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_e;
`else
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_e;
`endif

    localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

    state_e      state_q;
    logic        in_ready_q;
    logic        imem_we_q;
    logic [31:0] imem_addr_q;
    logic [31:0] imem_wdata_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_q;
`endif

    logic        xfer;
    logic [15:0] len_d;
    logic [31:0] word_d;
    logic [15:0] word_idx_d;

    assign xfer       = in_valid & in_ready_q;
    assign len_d      = {in_data, len_q[7:0]};
    assign word_d     = {in_data, word_q};
    assign word_idx_d = word_idx_q + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'd0;
            imem_wdata_q <= 32'd0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            len_q        <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_q       <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= 8'd0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q    <= LEN0;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        len_q      <= 16'd0;
                        word_idx_q <= 16'd0;
                        byte_cnt_q <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        chk_q      <= 8'd0;
`endif
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        len_q[7:0] <= in_data;
                        state_q    <= LEN1;
`ifdef LOADER_CHECKSUM_EN
                        chk_q      <= chk_q ^ in_data;
`endif
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        len_q <= len_d;
`ifdef LOADER_CHECKSUM_EN
                        chk_q <= chk_q ^ in_data;
`endif
                        if (len_d > MaxLen) begin
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else if (len_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q    <= CHK;
`else
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    // The final write cycle runs with in_ready low; completion follows it.
                    if (word_idx_q == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q    <= CHK;
                        in_ready_q <= 1'b1;
`else
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
`endif
                    end else if (xfer) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_q      <= chk_q ^ in_data;
`endif
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= in_data;
                            2'd1: word_q[15:8]  <= in_data;
                            2'd2: word_q[23:16] <= in_data;
                            default: begin
                                imem_we_q    <= 1'b1;
                                imem_wdata_q <= word_d;
                                imem_addr_q  <= ADDR_BASE + {14'd0, word_idx_q, 2'b00};
                                word_idx_q   <= word_idx_d;
                                if (word_idx_d == len_q) begin
                                    in_ready_q <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        if (in_data == chk_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scenario tasks drive byte streams while a scoreboard
// queue of expected {addr, data} writes is checked against every imem_we pulse.
module tb_imem_loader;

    localparam logic [31:0] Base = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int compared = 0;
    int mismatched = 0;
    int writeCount = 0;
    int stalls = 0;
    logic [7:0]  benchXor = 8'd0;
    logic [63:0] expQ[$];

    imem_loader #(.ADDR_BASE(Base), .MAX_WORDS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [63:0] exp;
            writeCount++;
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                exp = expQ.pop_front();
                if ({imem_addr, imem_wdata} !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) stalls++;
        benchXor = benchXor ^ b;
    endtask

    task automatic pulse_start();
        benchXor = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || error === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error} !== 69'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h, required 0",
                     {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error});
        end
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        check_bit("start_in_ready", in_ready, 1'b1);
        check_bit("start_cpu_hold", cpu_hold, 1'b1);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int w0 = writeCount;
        int s0 = stalls;
        logic [7:0] bytes[6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        expQ.push_back({Base, 32'hDEADBEEF});
        pulse_start();
        foreach (bytes[i]) send_byte(bytes[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(benchXor);
`endif
        in_valid = 1'b0;
        wait_done();
        check_bit("single_done", done, 1'b1);
        check_bit("single_cpu_hold", cpu_hold, 1'b0);
        check_bit("single_in_ready", in_ready, 1'b0);
        compared++;
        if (writeCount - w0 !== 1 || stalls !== s0 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL single_writes: got %0d writes %0d stalls, required 1 write 0 stalls",
                     writeCount - w0, stalls - s0);
        end
        compared++;
        if (imem_wdata !== 32'hDEADBEEF || imem_addr !== Base) begin
            mismatched++;
            $display("[TB] FAIL single_retain: got addr=%h data=%h, required %h/DEADBEEF", imem_addr, imem_wdata, Base);
        end
    endtask

    task automatic test_stall();
        int w0 = writeCount;
        int s0 = stalls;
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int w = 0; w < 3; w++) begin
            logic [31:0] word;
            for (int b = 0; b < 4; b++) word[8*b +: 8] = 8'(8'h10 + 4 * w + b);
            expQ.push_back({Base + 32'(4 * w), word});
            for (int b = 0; b < 4; b++) begin
                in_valid = 1'b0;
                repeat (2) @(negedge clk);
                send_byte(word[8*b +: 8]);
            end
            if (w == 0) check_bit("stall_ready_during_write", in_ready, 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(benchXor);
`endif
        in_valid = 1'b0;
        wait_done();
        check_bit("stall_done", done, 1'b1);
        compared++;
        if (writeCount - w0 !== 3 || stalls !== s0 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stall_writes: got %0d writes %0d stalls, required 3 writes 0 stalls",
                     writeCount - w0, stalls - s0);
        end
    endtask

    task automatic test_overflow();
        int w0 = writeCount;
        pulse_start();
        send_byte(8'h41);
        send_byte(8'h00);
        in_valid = 1'b0;
        check_bit("ovf_error", error, 1'b1);
        check_bit("ovf_in_ready", in_ready, 1'b0);
        check_bit("ovf_cpu_hold", cpu_hold, 1'b1);
        repeat (3) @(negedge clk);
        check_bit("ovf_error_held", error, 1'b1);
        compared++;
        if (writeCount !== w0) begin
            mismatched++;
            $display("[TB] FAIL ovf_writes: got %0d writes, required 0", writeCount - w0);
        end
        pulse_start();
        check_bit("ovf_recover_error", error, 1'b0);
        check_bit("ovf_recover_ready", in_ready, 1'b1);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(benchXor);
`endif
        in_valid = 1'b0;
        wait_done();
        check_bit("ovf_recover_done", done, 1'b1);
    endtask

    task automatic test_reset_midload();
        int w0 = writeCount;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        compared++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error} !== 69'd0) begin
            mismatched++;
            $display("[TB] FAIL midload_reset: got %h, required 0",
                     {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (writeCount !== w0) begin
            mismatched++;
            $display("[TB] FAIL midload_writes: got %0d writes, required 0", writeCount - w0);
        end
        expQ.push_back({Base, 32'h44332211});
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
`ifdef LOADER_CHECKSUM_EN
        send_byte(benchXor);
`endif
        in_valid = 1'b0;
        wait_done();
        check_bit("midload_reload_done", done, 1'b1);
        compared++;
        if (writeCount - w0 !== 1 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL midload_reload_writes: got %0d writes, required 1", writeCount - w0);
        end
    endtask

    task automatic test_zero_len();
        int w0 = writeCount;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        check_bit("zero_wait_chk", done, 1'b0);
        send_byte(benchXor);
`endif
        in_valid = 1'b0;
        check_bit("zero_done", done, 1'b1);
        check_bit("zero_cpu_hold", cpu_hold, 1'b0);
        repeat (2) @(negedge clk);
        compared++;
        if (writeCount !== w0) begin
            mismatched++;
            $display("[TB] FAIL zero_writes: got %0d writes, required 0", writeCount - w0);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] bytes[6] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        expQ.push_back({Base, 32'h12345678});
        pulse_start();
        foreach (bytes[i]) send_byte(bytes[i]);
        send_byte(8'h09);
        in_valid = 1'b0;
        wait_done();
        check_bit("chk_good_done", done, 1'b1);
        expQ.push_back({Base, 32'h12345678});
        pulse_start();
        foreach (bytes[i]) send_byte(bytes[i]);
        send_byte(8'h00);
        in_valid = 1'b0;
        wait_done();
        check_bit("chk_bad_error", error, 1'b1);
        check_bit("chk_bad_done", done, 1'b0);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL chk_writes: got %0d pending writes, required 0", expQ.size());
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single_word();
        test_stall();
        test_overflow();
        test_reset_midload();
        test_zero_len();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
